// File: rtl/rst_gen.sv
// rst_gen: reset sequencer for a downstream clock domain.
//
// Holds rst_n_out low for STRETCH_CYCLES clocks, then releases it and waits
// for the downstream domain to report that its synchronized reset has been
// released (a rising edge on rst_ack). The sequence ends with a one-cycle
// done pulse. If no acknowledge edge arrives within TIMEOUT_CYCLES clocks,
// the sticky timeout_err flag is set instead. A sequence starts at power-on
// (after rst) and again on each rising edge of sw_rst_req seen while idle.
//
// Ports:
//   clk          single clock for all sequential logic
//   rst          asynchronous, active-high reset (restarts the sequence)
//   sw_rst_req   software reset request, synchronous to clk, rising edge acts
//   rst_ack      downstream reset-released indicator, asynchronous to clk
//   rst_n_out    registered active-low reset to the downstream synchronizer
//   busy         high whenever the sequencer is not idle
//   done         one-cycle pulse when a sequence completes with acknowledge
//   timeout_err  sticky flag, set when the acknowledge wait times out
module rst_gen #(
    parameter int STRETCH_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_rst_req,
    input  logic rst_ack,
    output logic rst_n_out,
    output logic busy,
    output logic done,
    output logic timeout_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    // Terminal counter values: the counter starts at 0 on entry, so the last
    // cycle of a phase is the one where the counter reads N-1.
    localparam logic [7:0] STRETCH_LAST = 8'(STRETCH_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] counter;
    logic [7:0] counter_next;
    logic       rst_n_next;
    logic       done_next;
    logic       timeout_err_next;

    logic       ack_meta;
    logic       ack_s;
    logic       ack_d;
    logic       req_d;
    logic       req_edge;
    logic       ack_rise;

    // rst_ack comes from another domain: two flops to synchronize it, plus a
    // third so that only a 0->1 transition counts as an acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
            ack_d    <= 1'b0;
            req_d    <= 1'b0;
        end else begin
            ack_meta <= rst_ack;
            ack_s    <= ack_meta;
            ack_d    <= ack_s;
            req_d    <= sw_rst_req;
        end
    end

    assign req_edge = sw_rst_req & ~req_d;
    assign ack_rise = ack_s & ~ack_d;

    // Reset lands in ASSERT so that a power-on sequence runs with no request.
    // rst_n_out is a flop output, so the downstream reset never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ASSERT;
            counter     <= 8'd0;
            rst_n_out   <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            counter     <= counter_next;
            rst_n_out   <= rst_n_next;
            done        <= done_next;
            timeout_err <= timeout_err_next;
        end
    end

    // Next-state logic. Requests are only looked at in IDLE, so edges during
    // a sequence, or on the cycle WAIT_ACK exits, are dropped; req_d has
    // caught up by the time IDLE is reached. In WAIT_ACK the acknowledge is
    // tested before the timeout so that a coincident edge still completes.
    always_comb begin
        state_next       = state;
        counter_next     = (counter == 8'hFF) ? counter : counter + 8'd1;
        rst_n_next       = rst_n_out;
        done_next        = 1'b0;
        timeout_err_next = timeout_err;

        case (state)
            IDLE: begin
                counter_next = counter;
                if (req_edge) begin
                    state_next       = ASSERT;
                    counter_next     = 8'd0;
                    rst_n_next       = 1'b0;
                    timeout_err_next = 1'b0;
                end
            end
            ASSERT: begin
                rst_n_next = 1'b0;
                if (counter >= STRETCH_LAST) begin
                    state_next   = WAIT_ACK;
                    counter_next = 8'd0;
                    rst_n_next   = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (ack_rise) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else if (counter >= TIMEOUT_LAST) begin
                    state_next       = IDLE;
                    timeout_err_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_rst_gen.sv
// tb_rst_gen: self-checking bench for rst_gen with STRETCH_CYCLES = 4 and
// TIMEOUT_CYCLES = 10.
//
// Each reset sequence is predicted from its start point: the cycle index c
// counts clock edges since the request edge (or since rst release). From the
// stretch length, the cycle the bench raises rst_ack, the synchronizer
// latency and the timeout length, the bench works out where the sequence
// ends and whether it ends with done or with timeout_err, and from that the
// expected value of every output on every cycle.
module tb_rst_gen;

    localparam int S = 4;
    localparam int T = 10;
    // Cycles from raising rst_ack (just after an edge) to the edge that
    // accepts it: two synchronizer flops, then the edge-detect flop.
    localparam int ACK_LATENCY = 3;

    logic clk;
    logic rst;
    logic sw_rst_req;
    logic rst_ack;
    logic rst_n_out;
    logic busy;
    logic done;
    logic timeout_err;

    int checks = 0;
    int errors = 0;

    rst_gen #(
        .STRETCH_CYCLES (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw_rst_req  (sw_rst_req),
        .rst_ack     (rst_ack),
        .rst_n_out   (rst_n_out),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: got %b, expected %b", tag, obs, exp);
        end
    endtask

    // Reference model: ack raised j cycles after rst_n_out rises is accepted
    // if it gets through the synchronizer within the timeout window (ties go
    // to the acknowledge); otherwise the window runs out after T cycles.
    function automatic void predict(input int j, input bit static_ack,
                                    output int end_c, output bit acked);
        if (!static_ack && (j + ACK_LATENCY <= T)) begin
            acked = 1'b1;
            end_c = S + j + ACK_LATENCY;
        end else begin
            acked = 1'b0;
            end_c = S + T;
        end
    endfunction

    task automatic checkCycle(input string tag, input int c, input int end_c, input bit acked);
        checkOutput($sformatf("%s/rst_n_out c=%0d", tag, c), rst_n_out, logic'(c >= S));
        checkOutput($sformatf("%s/busy c=%0d", tag, c), busy, logic'(c < end_c));
        checkOutput($sformatf("%s/done c=%0d", tag, c), done, logic'(acked && c == end_c));
        checkOutput($sformatf("%s/timeout_err c=%0d", tag, c), timeout_err,
                    logic'(!acked && c >= end_c));
    endtask

    task automatic idleCheck(input string tag, input int n, input logic terr_exp);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput($sformatf("%s/rst_n_out i=%0d", tag, i), rst_n_out, 1'b1);
            checkOutput($sformatf("%s/busy i=%0d", tag, i), busy, 1'b0);
            checkOutput($sformatf("%s/done i=%0d", tag, i), done, 1'b0);
            checkOutput($sformatf("%s/timeout_err i=%0d", tag, i), timeout_err, terr_exp);
            @(posedge clk);
            #1;
        end
    endtask

    // Runs one sequence, started either by rst or by a one-cycle request.
    //   j          cycles after rst_n_out rises at which rst_ack is raised
    //   static_ack hold rst_ack high throughout (never an acknowledge edge)
    //   busy_req   toggle sw_rst_req during the sequence, then hold it high
    //              with a fresh rising edge on the exit cycle
    //   abort_c    cycle at which rst is pulsed mid-cycle (-1: never)
    task automatic applyStimulus(input string tag, input bit from_reset, input int j,
                                 input bit static_ack, input bit busy_req, input int abort_c);
        int end_c;
        bit acked;
        predict(j, static_ack, end_c, acked);
        if (from_reset) begin
            rst = 1'b1;
            #1;
            checkOutput({tag, "/rst_n_out in reset"}, rst_n_out, 1'b0);
            checkOutput({tag, "/busy in reset"}, busy, 1'b1);
            checkOutput({tag, "/done in reset"}, done, 1'b0);
            checkOutput({tag, "/timeout_err in reset"}, timeout_err, 1'b0);
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
        end else begin
            sw_rst_req = 1'b1;
            @(posedge clk);
            #1;
            sw_rst_req = 1'b0;
        end
        rst_ack = static_ack;
        for (int c = 0; c <= end_c + 3; c++) begin
            @(negedge clk);
            checkCycle(tag, c, end_c, acked);
            if (c == abort_c) begin
                #2;
                rst = 1'b1;
                #1;
                checkOutput({tag, "/rst_n_out async"}, rst_n_out, 1'b0);
                checkOutput({tag, "/busy async"}, busy, 1'b1);
                checkOutput({tag, "/done async"}, done, 1'b0);
                return;
            end
            @(posedge clk);
            #1;
            if (!static_ack && (c + 1 == S + j))
                rst_ack = 1'b1;
            if (busy_req) begin
                if (c + 1 == end_c - 1)
                    sw_rst_req = 1'b1;
                else if (c + 1 == end_c - 2)
                    sw_rst_req = 1'b0;
                else if (c + 1 < end_c - 2)
                    sw_rst_req = 1'($urandom_range(0, 1));
            end
        end
        if (busy_req)
            idleCheck({tag, "/held"}, 3, logic'(!acked));
        sw_rst_req = 1'b0;
        idleCheck({tag, "/idle"}, 1, logic'(!acked));
    endtask

    initial begin
        int j;
        bit st;
        bit br;
        rst        = 1'b1;
        sw_rst_req = 1'b0;
        rst_ack    = 1'b0;
        #1;

        applyStimulus("por", 1'b1, 3, 1'b0, 1'b0, -1);
        applyStimulus("sw_req", 1'b0, 2, 1'b0, 1'b0, -1);
        applyStimulus("timeout", 1'b0, 0, 1'b1, 1'b0, -1);
        idleCheck("timeout_sticky", 3, 1'b1);
        applyStimulus("clear_err", 1'b0, 1, 1'b0, 1'b0, -1);
        applyStimulus("busy_req", 1'b0, 4, 1'b0, 1'b1, -1);
        applyStimulus("coincide", 1'b0, T - ACK_LATENCY, 1'b0, 1'b0, -1);
        applyStimulus("mid_rst", 1'b0, 60, 1'b0, 1'b0, S + 1);
        applyStimulus("mid_rst_por", 1'b1, 2, 1'b0, 1'b0, -1);

        for (int k = 0; k < 10; k++) begin
            j  = int'($urandom_range(0, 12));
            st = ($urandom_range(0, 3) == 0);
            br = 1'($urandom_range(0, 1));
            applyStimulus($sformatf("rand%0d_j%0d_s%0d_b%0d", k, j, st, br),
                          1'b0, j, st, br, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
